vram_scanout: RTL and testbench

VGA-side reader of the column VRAM. It generates 640x480@60 raster timing and drives the VRAM read port with the current column index. It expands each 19-bit column entry (height, color, y_side) into per-row pixels: ceiling above the wall span, wall color inside it, floor below it. It sits between the VRAM read port and the VGA DAC/pins.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_timing.sv | 63 ++++++
 rtl/vram_scanout.sv | 129 ++++++++++++
 tb/tb_vram_scanout.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA scanout types: VRAM column entry, default 640x480@60 timing and RGB332 shading.
package vga_pkg;

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned HEIGHT_W = 10;
  localparam int unsigned SPAN_W   = 11;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam logic [PIX_W-1:0] VGA_CEIL_COLOR  = 8'h49;
  localparam logic [PIX_W-1:0] VGA_FLOOR_COLOR = 8'h24;

  typedef struct packed {
    logic [HEIGHT_W-1:0] height;
    logic [PIX_W-1:0]    color;
    logic                y_side;
  } vram_entry_t;

  localparam int unsigned ENTRY_W = $bits(vram_entry_t);

  // Halves each RGB332 channel: shift right, then drop bits that leaked across channel boundaries.
  function automatic logic [PIX_W-1:0] shade(input logic [PIX_W-1:0] color);
    return (color >> 1) & 8'h6D;
  endfunction

  function automatic logic [PIX_W-1:0] wall_color(input vram_entry_t entry, input logic shade_en);
    return (shade_en && entry.y_side) ? shade(entry.color) : entry.color;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters for VGA plus raw (unpipelined) sync, visible and vblank flags.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             visible_c,
  output logic             hsync_c,
  output logic             vsync_c,
  output logic             vblank_c
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + ONE;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt     = h_cnt_q;
  assign v_cnt     = v_cnt_q;
  assign visible_c = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign hsync_c   = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
  assign vsync_c   = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
  assign vblank_c  = (h_cnt_q == '0) && (v_cnt_q == V_VIS);

endmodule

// File: rtl/vram_scanout.sv
// VGA-side VRAM column reader: raster timing, 2-stage read pipeline and ceiling/wall/floor expansion.
// Wall shading by y_side is enabled with `define VRAM_SCANOUT_SHADE_EN.
module vram_scanout
  import vga_pkg::*;
#(
  parameter int unsigned      H_VISIBLE   = VGA_H_VISIBLE,
  parameter int unsigned      H_FRONT     = VGA_H_FRONT,
  parameter int unsigned      H_SYNC      = VGA_H_SYNC,
  parameter int unsigned      H_BACK      = VGA_H_BACK,
  parameter int unsigned      V_VISIBLE   = VGA_V_VISIBLE,
  parameter int unsigned      V_FRONT     = VGA_V_FRONT,
  parameter int unsigned      V_SYNC      = VGA_V_SYNC,
  parameter int unsigned      V_BACK      = VGA_V_BACK,
  parameter logic [PIX_W-1:0] CEIL_COLOR  = VGA_CEIL_COLOR,
  parameter logic [PIX_W-1:0] FLOOR_COLOR = VGA_FLOOR_COLOR
) (
  input  logic               clk,
  input  logic               rst,
  output logic [CNT_W-1:0]   raddr,
  input  logic [ENTRY_W-1:0] rdata,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [PIX_W-1:0]   pixel,
  output logic               vblank_start
);

`ifdef VRAM_SCANOUT_SHADE_EN
  localparam logic SHADE_EN = 1'b1;
`else
  localparam logic SHADE_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0]         H_VIS  = CNT_W'(H_VISIBLE);
  localparam logic signed [SPAN_W-1:0] CENTER = SPAN_W'(V_VISIBLE / 2);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             visible_c, hsync_c, vsync_c, vblank_c;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .visible_c (visible_c),
    .hsync_c   (hsync_c),
    .vsync_c   (vsync_c),
    .vblank_c  (vblank_c)
  );

  assign raddr = (h_cnt < H_VIS) ? h_cnt : '0;

  // S1: row and raw flags travel alongside the in-flight VRAM read.
  logic [CNT_W-1:0] v1_q, v1_d;
  logic             vis1_q, vis1_d, hs1_q, hs1_d, vs1_q, vs1_d, vb1_q, vb1_d;
  // S2: output registers.
  logic [PIX_W-1:0] pixel_q, pixel_d;
  logic             de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d, vb_q, vb_d;

  vram_entry_t               entry;
  logic [HEIGHT_W-1:0]       half;
  logic signed [SPAN_W-1:0]  y_s, lo_s, hi_s;

  assign entry = vram_entry_t'(rdata);
  assign half  = entry.height >> 1;
  assign y_s   = $signed({1'b0, v1_q});
  assign lo_s  = CENTER - $signed({1'b0, half});
  assign hi_s  = CENTER + $signed({1'b0, half});

  always_comb begin
    v1_d    = v_cnt;
    vis1_d  = visible_c;
    hs1_d   = hsync_c;
    vs1_d   = vsync_c;
    vb1_d   = vblank_c;
    de_d    = vis1_q;
    hsync_d = hs1_q;
    vsync_d = vs1_q;
    vb_d    = vb1_q;
    pixel_d = '0;
    if (vis1_q) begin
      if (y_s < lo_s)      pixel_d = CEIL_COLOR;
      else if (y_s < hi_s) pixel_d = wall_color(entry, SHADE_EN);
      else                 pixel_d = FLOOR_COLOR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= '0;
      vis1_q  <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      vb1_q   <= 1'b0;
      pixel_q <= '0;
      de_q    <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      vb_q    <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      vis1_q  <= vis1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      vb1_q   <= vb1_d;
      pixel_q <= pixel_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      vb_q    <= vb_d;
    end
  end

  assign pixel        = pixel_q;
  assign de           = de_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign vblank_start = vb_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout: a full-timing instance and a narrow-line instance (full vertical timing)
// checked cycle by cycle against a position-based reference model, plus a table of span vectors.
module tb_vram_scanout;

  localparam int SHV = 16, SHF = 2, SHS = 4, SHB = 3, SHT = SHV + SHF + SHS + SHB;
  localparam int BHV = 640, BHF = 16, BHS = 96, BHB = 48, BHT = BHV + BHF + BHS + BHB;
  localparam int VV = 480, VF = 10, VS = 2, VB = 33, VT = VV + VF + VS + VB;
  localparam int FS = SHT * VT;

`ifdef VRAM_SCANOUT_SHADE_EN
  localparam bit SHADE = 1'b1;
`else
  localparam bit SHADE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  raddr_s, raddr_b;
  logic [18:0] rdata_s, rdata_b;
  logic        hsync_s, vsync_s, de_s, vb_s, hsync_b, vsync_b, de_b, vb_b;
  logic [7:0]  pixel_s, pixel_b;

  vram_scanout #(.H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB)) dut_s (
    .clk(clk), .rst(rst), .raddr(raddr_s), .rdata(rdata_s), .hsync(hsync_s),
    .vsync(vsync_s), .de(de_s), .pixel(pixel_s), .vblank_start(vb_s));

  vram_scanout dut_b (
    .clk(clk), .rst(rst), .raddr(raddr_b), .rdata(rdata_b), .hsync(hsync_b),
    .vsync(vsync_b), .de(de_b), .pixel(pixel_b), .vblank_start(vb_b));

  logic [18:0] mem_s [0:SHV-1];
  logic [18:0] mem_b [0:BHV-1];
  logic [7:0]  cap   [0:VV-1][0:SHV-1];

  always @(posedge clk) begin
    rdata_s <= mem_s[raddr_s];
    rdata_b <= mem_b[raddr_b];
  end

  int n = 0;
  always @(posedge clk or posedge rst)
    if (rst) n <= 0;
    else     n <= n + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h n=%0d t=%0t", name, act, exp, n, $time);
    end
  endtask

  function automatic logic [7:0] ref_pixel(input int y, input logic [18:0] e);
    int height, half;
    logic [7:0] col;
    height = int'(e[18:9]);
    half   = height / 2;
    col    = e[8:1];
    if (y < VV / 2 - half) return 8'h49;
    if (y < VV / 2 + half) return (SHADE && e[0]) ? ((col >> 1) & 8'h6D) : col;
    return 8'h24;
  endfunction

  typedef struct {
    int         h;
    int         v;
    logic [9:0] raddr;
    logic       hs, vs, de, vb;
    logic [7:0] pix;
  } exp_t;

  // Expected outputs for n clocks after reset release: counters sit at position n, outputs show n-2.
  task automatic model(input int cnt, input int hv, input int hf, input int hs, input int hb,
                       input bit big, output exp_t x);
    int ht, hn, p;
    ht = hv + hf + hs + hb;
    hn = cnt % ht;
    x.raddr = (hn < hv) ? 10'(hn) : 10'd0;
    x.h = 0; x.v = 0; x.hs = 1'b1; x.vs = 1'b1; x.de = 1'b0; x.vb = 1'b0; x.pix = 8'h00;
    if (rst || cnt < 2) return;
    p    = cnt - 2;
    x.h  = p % ht;
    x.v  = (p / ht) % VT;
    x.de = (x.h < hv) && (x.v < VV);
    x.hs = !(x.h >= hv + hf && x.h < hv + hf + hs);
    x.vs = !(x.v >= VV + VF && x.v < VV + VF + VS);
    x.vb = (x.h == 0) && (x.v == VV);
    if (x.de) x.pix = ref_pixel(x.v, big ? mem_b[x.h] : mem_s[x.h]);
  endtask

  exp_t es, eb;
  int   s_de, s_vb, s_vsl, b_hsl, b_de;
  bit   seen_fall;
  logic hprev;

  always @(negedge clk) begin
    model(n, SHV, SHF, SHS, SHB, 1'b0, es);
    model(n, BHV, BHF, BHS, BHB, 1'b1, eb);
    chk("s_raddr", int'(raddr_s), int'(es.raddr));
    chk("s_hsync", int'(hsync_s), int'(es.hs));
    chk("s_vsync", int'(vsync_s), int'(es.vs));
    chk("s_de",    int'(de_s),    int'(es.de));
    chk("s_pixel", int'(pixel_s), int'(es.pix));
    chk("s_vblank_start", int'(vb_s), int'(es.vb));
    chk("b_raddr", int'(raddr_b), int'(eb.raddr));
    chk("b_hsync", int'(hsync_b), int'(eb.hs));
    chk("b_vsync", int'(vsync_b), int'(eb.vs));
    chk("b_de",    int'(de_b),    int'(eb.de));
    chk("b_pixel", int'(pixel_b), int'(eb.pix));
    chk("b_vblank_start", int'(vb_b), int'(eb.vb));
    if (!rst && n >= 2 && es.de) cap[es.v][es.h] = pixel_s;
    if (rst) begin
      s_de = 0; s_vb = 0; s_vsl = 0; b_hsl = 0; b_de = 0; seen_fall = 1'b0;
    end else if (n >= 2) begin
      s_de  += int'(de_s);
      s_vb  += int'(vb_s);
      s_vsl += int'(!vsync_s);
      if ((n - 2) % FS == FS - 1) begin
        chk("s_frame_de_count", s_de, SHV * VV);
        chk("s_frame_vblank_pulses", s_vb, 1);
        chk("s_frame_vsync_low_clks", s_vsl, VS * SHT);
        s_de = 0; s_vb = 0; s_vsl = 0;
      end
      b_hsl += int'(!hsync_b);
      b_de  += int'(de_b);
      if ((n - 2) % BHT == BHT - 1) begin
        chk("b_line_hsync_low_clks", b_hsl, BHS);
        chk("b_line_de_count", b_de, (((n - 2) / BHT) % VT < VV) ? BHV : 0);
        b_hsl = 0; b_de = 0;
      end
      if (!seen_fall && hprev && !hsync_b) begin
        chk("b_first_hsync_fall_clk", n, BHV + BHF + 2);
        seen_fall = 1'b1;
      end
    end
    hprev = hsync_b;
  end

  task automatic wait_n(input int target);
    int k;
    k = 0;
    while (n < target && k < 200000) begin
      @(negedge clk);
      k++;
    end
    if (n < target) chk("wait_timeout", n, target);
  endtask

  typedef struct {
    logic [9:0] height;
    logic [7:0] color;
    logic       y_side;
    int         row;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [0:13];

  initial begin
    tbl[0]  = '{10'd100,  8'hE0, 1'b0, 189, 8'h49};
    tbl[1]  = '{10'd100,  8'hE0, 1'b0, 190, 8'hE0};
    tbl[2]  = '{10'd100,  8'hE0, 1'b0, 289, 8'hE0};
    tbl[3]  = '{10'd0,    8'hE0, 1'b0, 239, 8'h49};
    tbl[4]  = '{10'd0,    8'hE0, 1'b0, 240, 8'h24};
    tbl[5]  = '{10'd100,  8'hE0, 1'b0, 290, 8'h24};
    tbl[6]  = '{10'd1023, 8'h1C, 1'b0, 0,   8'h1C};
    tbl[7]  = '{10'd1023, 8'h1C, 1'b0, 479, 8'h1C};
    tbl[8]  = '{10'd200,  8'hFF, 1'b1, 240, SHADE ? 8'h6D : 8'hFF};
    tbl[9]  = '{10'd479,  8'h03, 1'b0, 0,   8'h49};
    tbl[10] = '{10'd479,  8'h03, 1'b0, 1,   8'h03};
    tbl[11] = '{10'd479,  8'h03, 1'b0, 479, 8'h24};
    tbl[12] = '{10'd101,  8'hE0, 1'b0, 290, 8'h24};
    tbl[13] = '{10'd480,  8'h92, 1'b1, 0,   SHADE ? 8'h49 : 8'h92};
    for (int i = 0; i < SHV; i++)
      mem_s[i] = (i < 14) ? {tbl[i].height, tbl[i].color, tbl[i].y_side} : 19'($urandom);
    for (int i = 0; i < BHV; i++) mem_b[i] = 19'($urandom);

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Asynchronous reset mid-frame: narrow instance at line 100, column 10.
    wait_n(100 * SHT + 10);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_b_raddr", int'(raddr_b), 0);
    chk("async_rst_b_de",    int'(de_b),    0);
    chk("async_rst_b_pixel", int'(pixel_b), 0);
    chk("async_rst_s_hsync", int'(hsync_s), 1);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Span table, read back from the first captured frame once its visible rows are done.
    wait_n(2 + (VV + 1) * SHT);
    for (int i = 0; i < 14; i++)
      chk($sformatf("table_col%0d_row%0d", i, tbl[i].row), int'(cap[tbl[i].row][i]), int'(tbl[i].exp));

    for (int i = 0; i < SHV; i++) mem_s[i] = 19'($urandom);
    wait_n(2 + 3 * FS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
